// File: rtl/seq_calculator.sv
`default_nettype none
// ============================================================================
// seq_calculator : handshaked add/sub/mul/div; mul is shift-add, div restoring
// Rev 1.0 - initial release
// ============================================================================
module seq_calculator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  invalid_input
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]            state_q,     state_d;
  logic                  is_div_q,    is_div_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  // acc: product accumulator (MUL) or quotient (DIV)
  logic [DATA_WIDTH-1:0] acc_q,       acc_d;
  // mcand: shifted multiplicand (MUL) or dividend shifted out MSB-first (DIV)
  logic [DATA_WIDTH-1:0] mcand_q,     mcand_d;
  // mplier: multiplier (MUL) or divisor (DIV)
  logic [DATA_WIDTH-1:0] mplier_q,    mplier_d;
  logic [DATA_WIDTH-1:0] prem_q,      prem_d;
  logic [DATA_WIDTH-1:0] result_q,    result_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  invalid_q,   invalid_d;

  logic [DATA_WIDTH-1:0] w_mul_acc;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic                  w_rem_ge;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_quot_nxt;

  always_comb begin
    w_mul_acc   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    w_rem_shift = {prem_q, mcand_q[DATA_WIDTH-1]};
    w_rem_ge    = (w_rem_shift >= {1'b0, mplier_q});
    // When the subtraction is skipped the shifted value is below the divisor, so its MSB is zero
    w_rem_nxt   = w_rem_ge ? DATA_WIDTH'(w_rem_shift - {1'b0, mplier_q})
                           : w_rem_shift[DATA_WIDTH-1:0];
    w_quot_nxt  = {acc_q[DATA_WIDTH-2:0], w_rem_ge};
  end

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prem_d      = prem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    invalid_d   = invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_ADD || op == OP_SUB) begin
            result_d    = (op == OP_ADD) ? (a + b) : (a - b);
            remainder_d = '0;
            invalid_d   = 1'b0;
            state_d     = ST_DONE;
          end else if (op != OP_MUL && b == '0) begin
            result_d    = '0;
            remainder_d = '0;
            invalid_d   = 1'b1;
            state_d     = ST_DONE;
          end else begin
            is_div_d = (op != OP_MUL);
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            prem_d   = '0;
            cnt_d    = CNT_INIT;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (is_div_q) begin
          acc_d  = w_quot_nxt;
          prem_d = w_rem_nxt;
        end else begin
          acc_d    = w_mul_acc;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == '0) begin
          result_d    = is_div_q ? w_quot_nxt : w_mul_acc;
          remainder_d = is_div_q ? w_rem_nxt : '0;
          invalid_d   = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prem_q      <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prem_q      <= prem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      invalid_q   <= invalid_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign result        = result_q;
  assign remainder     = remainder_q;
  assign invalid_input = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_calculator.sv
`default_nettype none
// ============================================================================
// tb_seq_calculator : directed self-checking bench for seq_calculator (W=16)
// Rev 1.0 - initial release
// ============================================================================
module tb_seq_calculator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         invalid_input;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  seq_calculator #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .remainder    (remainder),
    .invalid_input(invalid_input)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; the DUT is idle whenever this is called
  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    op       = o;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // lat counts cycles after the accept edge; rdy records any in_ready seen before and at out_valid
  task automatic wait_out(output int lat, output logic rdy);
    lat = 1;
    rdy = in_ready;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
      rdy = rdy | in_ready;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] e_res, input logic [W-1:0] e_rem,
                        input logic e_inv, input int e_lat);
    int   lat;
    logic rdy;
    issue(o, aa, bb);
    wait_out(lat, rdy);
    chk({tag, " latency"},   32'(lat), 32'(e_lat));
    chk({tag, " busy_rdy"},  {31'd0, rdy}, 32'd0);
    chk({tag, " result"},    {16'd0, result}, {16'd0, e_res});
    chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, e_rem});
    chk({tag, " invalid"},   {31'd0, invalid_input}, {31'd0, e_inv});
    out_ready = 1'b1;
    step();
    chk({tag, " ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic rdy;
    logic seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = ADD;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst result",    {16'd0, result}, 32'd0);
    chk("rst remainder", {16'd0, remainder}, 32'd0);
    chk("rst invalid",   {31'd0, invalid_input}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add_wrap",  ADD, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b0, 1);
    run_op("sub_wrap",  SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1);
    run_op("div_1000_7", DIV, 16'd1000, 16'd7,   16'd142,  16'd6,    1'b0, 17);
    run_op("mul_300",   MUL, 16'd300,  16'd300,  16'h5F90, 16'h0000, 1'b0, 17);
    run_op("div_by0",   DIV, 16'd5,    16'd0,    16'd0,    16'd0,    1'b1, 1);
    run_op("div_a_lt_b", DIV, 16'd3,   16'd10,   16'd0,    16'd3,    1'b0, 17);
    run_op("div_b1",    DIV, 16'd1234, 16'd1,    16'd1234, 16'd0,    1'b0, 17);
    run_op("mul_zero",  MUL, 16'd0,    16'd500,  16'd0,    16'd0,    1'b0, 17);
    run_op("div_big",   DIV, 16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 17);

    // Backpressure: result must hold while a competing request is refused
    out_ready = 1'b0;
    issue(MUL, 16'd3, 16'd4);
    wait_out(lat, rdy);
    chk("bp latency", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      op       = ADD;
      a        = 16'h0063;
      b        = 16'h0001;
      in_valid = 1'b1;
      step();
      chk("bp result",   {16'd0, result}, 32'd12);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp done valid", {31'd0, out_valid}, 32'd0);
    chk("bp done ready", {31'd0, in_ready}, 32'd1);
    chk("bp held result", {16'd0, result}, 32'd12);
    step();
    chk("bp no stray accept", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a division
    issue(DIV, 16'd60000, 16'd3);
    repeat (7) step();
    chk("mid busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid rst in_ready",  {31'd0, in_ready}, 32'd1);
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst result",    {16'd0, result}, 32'd0);
    chk("mid rst remainder", {16'd0, remainder}, 32'd0);
    chk("mid rst invalid",   {31'd0, invalid_input}, 32'd0);
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen = seen | out_valid;
    end
    chk("mid rst no output", {31'd0, seen}, 32'd0);
    chk("mid rst idle", {31'd0, in_ready}, 32'd1);
    run_op("add_after_rst", ADD, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
Multi-cycle, handshaked successor to the combinational calculator. It accepts one operation (add/sub/mul/div) per transaction over a valid/ready input channel. Add and sub complete in one cycle. Mul uses an iterative shift-add datapath and div uses restoring division, taking DATA_WIDTH iterations. Results, remainder and an invalid-input flag are returned over a valid/ready output channel, so the block can sit between pipelined producers and consumers with backpressure.

Parameters:
DATA_WIDTH, 16, operand/result width in bits (>= 2).

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request
a  input  DATA_WIDTH  operand A (unsigned)
b  input  DATA_WIDTH  operand B (unsigned)
op  input  2  00=ADD, 01=SUB, 10=MUL, 11=DIV
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  sum/difference/low product bits/quotient
remainder  output  DATA_WIDTH  DIV remainder; 0 for other ops
invalid_input  output  1  1 = DIV with b==0 (result=0, remainder=0)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, result=0, remainder=0, invalid_input=0, iteration counter=0, operand registers=0.
- Accept: handshake when in_valid && in_ready at a rising edge (cycle T). a, b and op are latched at that edge. Inputs are ignored at all other times.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On accept with ADD, SUB, or DIV with b==0: compute and go to DONE.
    - On accept with MUL, or DIV with b!=0: load the datapath, set counter=DATA_WIDTH-1, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. One iteration per cycle, counter decrements. The iteration done with counter==0 is the last; the result registers load and the state goes to DONE.
  - DONE: in_ready=0, out_valid=1. result, remainder and invalid_input are held stable. Go to IDLE on out_ready.
- Latency (out_valid first high in the cycle after the edge):
  - ADD/SUB/DIV-by-zero: out_valid high in cycle T+1.
  - MUL/DIV: out_valid high in cycle T+DATA_WIDTH+1.
- No same-cycle accept while DONE. The next accept is possible at the earliest in the cycle after the output handshake, so throughput is 1 op per 2 cycles for ADD/SUB.
- Arithmetic (unsigned, modulo 2^DATA_WIDTH):
  - ADD: (a+b) mod 2^W; carry is discarded.
  - SUB: (a-b) mod 2^W; 0-1 gives all-ones.
  - MUL: low W bits of a*b; high bits are discarded.
  - DIV: quotient=floor(a/b), remainder=a mod b.
  - remainder=0 for ADD/SUB/MUL. invalid_input=0 for all ops except DIV with b==0.
- MUL datapath: per iteration, if the multiplier LSB is 1, add the shifted multiplicand to the W-bit accumulator. Then shift the multiplicand left and the multiplier right.
- DIV datapath (restoring): per iteration:
  - Shift {rem,quot} left by 1, bringing in the dividend MSB.
  - If rem >= b: rem -= b and set the quotient LSB.
  - Partial remainder needs W+1 bits.
- Output registers only update on entry to DONE. Between transactions they keep the last values; out_valid qualifies them.
- Boundary conditions:
  - a==0 or b==0 for MUL: result 0, still takes full latency.
  - a<b for DIV: quotient 0, remainder a.
  - b==1 for DIV: quotient a, remainder 0.
  - Reset asserted in BUSY or DONE: the operation is aborted immediately, all outputs take reset values, and no result is emitted after release.
  - in_valid held high while busy: not accepted until IDLE. The request must be held by the producer.
  - out_ready high before out_valid: no effect.

Test Plan:
- Width=16. ADD a=0xFFFF, b=0x0002, out_ready=1 -> result=0x0001, remainder=0, invalid=0, out_valid in cycle T+1.
- SUB a=0x0000, b=0x0001 -> result=0xFFFF, out_valid at T+1; then in_ready returns to 1 the cycle after the output handshake.
- MUL a=300, b=300 -> result=0x5F90 (90000 mod 65536), remainder=0, out_valid first high at T+17; in_ready=0 for cycles T+1..T+17.
- DIV a=1000, b=7 -> result=142, remainder=6, invalid=0 at T+17. DIV a=5, b=0 -> result=0, remainder=0, invalid=1 at T+1.
- Backpressure: MUL 3*4 with out_ready=0 for 5 cycles after out_valid -> result=12 held stable, out_valid=1, in_ready=0 throughout. A new in_valid with a changed a during the hold is not accepted. Completes on out_ready=1.
- Reset mid-op: DIV 60000/3, rst_n low for 1 cycle at T+8 -> all outputs 0, in_ready=1 after release, no out_valid. A subsequent ADD 1+1 gives result 2.
